// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - single write port arbiter for the register file
// Round-robin between ALU (A) and load (B) writeback, plus a post-reset zero-clear sequencer.
module regfile_write_arbiter #(
  parameter int W  = 8,
  parameter int A  = 3,
  parameter int CW = 8
) (
  input  logic          Clk,
  input  logic          ResetN,
  input  logic          ClearReq,
  input  logic          AValid,
  input  logic [A-1:0]  AAddr,
  input  logic [W-1:0]  AData,
  output logic          AReady,
  input  logic          BValid,
  input  logic [A-1:0]  BAddr,
  input  logic [W-1:0]  BData,
  output logic          BReady,
  output logic          WriteEn,
  output logic [A-1:0]  Waddr,
  output logic [W-1:0]  DataIn,
  output logic          Busy,
  output logic [CW-1:0] ConflictCnt
);

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t         state, state_nxt;
  logic [A-1:0]   cnt, cnt_nxt;
  logic           ptr_b, ptr_b_nxt;
  logic [CW-1:0]  conflict_nxt;
  logic           we_nxt;
  logic [A-1:0]   waddr_nxt;
  logic [W-1:0]   data_nxt;

  assign Busy = (state == CLEAR);

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state       <= CLEAR;
      cnt         <= '0;
      ptr_b       <= 1'b0;
      WriteEn     <= 1'b0;
      Waddr       <= '0;
      DataIn      <= '0;
      ConflictCnt <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      ptr_b       <= ptr_b_nxt;
      WriteEn     <= we_nxt;
      Waddr       <= waddr_nxt;
      DataIn      <= data_nxt;
      ConflictCnt <= conflict_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    ptr_b_nxt    = ptr_b;
    conflict_nxt = ConflictCnt;
    we_nxt       = 1'b0;
    waddr_nxt    = Waddr;
    data_nxt     = DataIn;
    AReady       = 1'b0;
    BReady       = 1'b0;

    case (state)
      CLEAR: begin
        we_nxt    = 1'b1;
        waddr_nxt = cnt;
        data_nxt  = '0;
        if (cnt == '1) begin
          cnt_nxt   = '0;
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt + A'(1);
        end
      end
      RUN: begin
        // A clear request pre-empts both requesters for this cycle.
        if (ClearReq) begin
          state_nxt = CLEAR;
        end else if (AValid && BValid) begin
          if (ptr_b) BReady = 1'b1;
          else       AReady = 1'b1;
          ptr_b_nxt = ~ptr_b;
          if (ConflictCnt != '1) conflict_nxt = ConflictCnt + CW'(1);
        end else if (AValid) begin
          AReady = 1'b1;
        end else if (BValid) begin
          BReady = 1'b1;
        end

        if (AReady) begin
          we_nxt    = 1'b1;
          waddr_nxt = AAddr;
          data_nxt  = AData;
        end else if (BReady) begin
          we_nxt    = 1'b1;
          waddr_nxt = BAddr;
          data_nxt  = BData;
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - scoreboard bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

  logic       Clk = 1'b0;
  logic       ResetN = 1'b0;
  logic       ClearReq = 1'b0;
  logic       AValid = 1'b0;
  logic [2:0] AAddr = '0;
  logic [7:0] AData = '0;
  logic       AReady;
  logic       BValid = 1'b0;
  logic [2:0] BAddr = '0;
  logic [7:0] BData = '0;
  logic       BReady;
  logic       WriteEn;
  logic [2:0] Waddr;
  logic [7:0] DataIn;
  logic       Busy;
  logic [7:0] ConflictCnt;

  int checks = 0;
  int errors = 0;
  logic [10:0] exp_q[$];

  regfile_write_arbiter #(.W(8), .A(3), .CW(8)) dut (
    .Clk(Clk), .ResetN(ResetN), .ClearReq(ClearReq),
    .AValid(AValid), .AAddr(AAddr), .AData(AData), .AReady(AReady),
    .BValid(BValid), .BAddr(BAddr), .BData(BData), .BReady(BReady),
    .WriteEn(WriteEn), .Waddr(Waddr), .DataIn(DataIn),
    .Busy(Busy), .ConflictCnt(ConflictCnt)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write presented to the register file must match the head of the queue.
  initial begin
    forever begin
      @(posedge Clk);
      #1;
      if (ResetN && WriteEn) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {21'd0, Waddr, DataIn}, 32'hFFFF_FFFF);
        end else begin
          chk("write", {21'd0, Waddr, DataIn}, {21'd0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic step(input logic av, input logic [2:0] aa, input logic [7:0] ad,
                      input logic bv, input logic [2:0] ba, input logic [7:0] bd,
                      input logic clr, input logic ea, input logic eb, input string tag);
    @(negedge Clk);
    AValid = av; AAddr = aa; AData = ad;
    BValid = bv; BAddr = ba; BData = bd;
    ClearReq = clr;
    #1;
    chk({tag, "_aready"}, {31'd0, AReady}, {31'd0, ea});
    chk({tag, "_bready"}, {31'd0, BReady}, {31'd0, eb});
    if (ea) exp_q.push_back({aa, ad});
    if (eb) exp_q.push_back({ba, bd});
  endtask

  task automatic idle(input string tag);
    step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, tag);
  endtask

  task automatic push_clear();
    for (int i = 0; i < 8; i++) exp_q.push_back({i[2:0], 8'h00});
  endtask

  // Releases reset and checks Busy over the full eight-cycle clear.
  task automatic release_and_clear(input string tag);
    push_clear();
    @(negedge Clk);
    ResetN = 1'b1;
    #1;
    chk({tag, "_busy0"}, {31'd0, Busy}, 32'd1);
    for (int i = 1; i < 8; i++) begin
      idle(tag);
      chk({tag, "_busy"}, {31'd0, Busy}, 32'd1);
    end
    idle(tag);
    chk({tag, "_busy_low"}, {31'd0, Busy}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ga;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_we", {31'd0, WriteEn}, 32'd0);
    chk("rst_waddr", {29'd0, Waddr}, 32'd0);
    chk("rst_data", {24'd0, DataIn}, 32'd0);
    chk("rst_conflict", {24'd0, ConflictCnt}, 32'd0);
    chk("rst_busy", {31'd0, Busy}, 32'd1);

    release_and_clear("init");
    idle("init_tail");

    step(1'b1, 3'd3, 8'h5A, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, "singleA");
    idle("singleA_after");
    idle("singleA_after2");

    step(1'b1, 3'd1, 8'h11, 1'b1, 3'd2, 8'h22, 1'b0, 1'b1, 1'b0, "conf1");
    step(1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 8'h22, 1'b0, 1'b0, 1'b1, "conf1_b");
    chk("conflict_cnt1", {24'd0, ConflictCnt}, 32'd1);
    step(1'b1, 3'd4, 8'h44, 1'b1, 3'd5, 8'h55, 1'b0, 1'b0, 1'b1, "conf2");
    step(1'b1, 3'd4, 8'h44, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, "conf2_a");
    step(1'b1, 3'd6, 8'h66, 1'b1, 3'd7, 8'h77, 1'b0, 1'b1, 1'b0, "conf3");
    step(1'b0, 3'd0, 8'h00, 1'b1, 3'd7, 8'h77, 1'b0, 1'b0, 1'b1, "conf3_b");
    idle("conf_tail");
    chk("conflict_cnt3", {24'd0, ConflictCnt}, 32'd3);

    // Pointer names B here, so the sustained conflict grants B,A,B,...
    for (int i = 0; i < 300; i++) begin
      ga = i[0];
      step(1'b1, i[2:0], i[7:0], 1'b1, ~i[2:0], ~i[7:0], 1'b0, ga, ~ga, "alt");
    end
    idle("alt_tail");
    chk("conflict_sat", {24'd0, ConflictCnt}, 32'd255);
    idle("alt_tail2");
    chk("conflict_hold", {24'd0, ConflictCnt}, 32'd255);

    step(1'b1, 3'd2, 8'hC3, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0, "clrreq");
    push_clear();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 3'd2, 8'hC3, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, "clr_wait");
      chk("clr_busy", {31'd0, Busy}, 32'd1);
    end
    step(1'b1, 3'd2, 8'hC3, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, "clr_grant");
    chk("clr_busy_low", {31'd0, Busy}, 32'd0);
    idle("clr_tail");

    step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0, "midrst_req");
    push_clear();
    for (int i = 0; i < 4; i++) idle("midrst_run");
    @(posedge Clk);
    @(negedge Clk);
    ResetN = 1'b0;
    #1;
    chk("midrst_we", {31'd0, WriteEn}, 32'd0);
    chk("midrst_waddr", {29'd0, Waddr}, 32'd0);
    chk("midrst_data", {24'd0, DataIn}, 32'd0);
    chk("midrst_conflict", {24'd0, ConflictCnt}, 32'd0);
    chk("midrst_busy", {31'd0, Busy}, 32'd1);
    chk("midrst_pending", exp_q.size(), 32'd4);
    exp_q.delete();
    @(negedge Clk);
    release_and_clear("restart");
    idle("end1");
    idle("end2");
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
